// File: rtl/mips_bus_arbiter_if.sv
// Avalon-MM port bundle, used for the two requester ports and the shared downstream port.
// The master modport drives the request; the slave modport answers with waitrequest/readdata.
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for one Avalon-MM slave port.
// Whole transactions are granted; the data path is combinational from the owner state.
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_bus_arbiter_if.slave  m0,
    mips_bus_arbiter_if.slave  m1,
    mips_bus_arbiter_if.master mem,
    output logic [1:0]         grant
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    logic   last;
    logic   req0;
    logic   req1;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // grant is registered alongside state so it always matches the current owner.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (req1) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (!mem.waitrequest) begin
                        last <= 1'b0;
                        if (req1) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (!mem.waitrequest) begin
                        last <= 1'b1;
                        if (req0) begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem.address    = {ADDR_W{1'b0}};
        mem.read       = 1'b0;
        mem.write      = 1'b0;
        mem.writedata  = {DATA_W{1'b0}};
        mem.byteenable = {(DATA_W/8){1'b0}};
        m0.waitrequest = 1'b1;
        m0.readdata    = {DATA_W{1'b0}};
        m1.waitrequest = 1'b1;
        m1.readdata    = {DATA_W{1'b0}};
        case (state)
            OWN0: begin
                mem.address    = m0.address;
                mem.read       = m0.read;
                mem.write      = m0.write;
                mem.writedata  = m0.writedata;
                mem.byteenable = m0.byteenable;
                m0.waitrequest = mem.waitrequest;
                m0.readdata    = mem.readdata;
            end
            OWN1: begin
                mem.address    = m1.address;
                mem.read       = m1.read;
                mem.write      = m1.write;
                mem.writedata  = m1.writedata;
                mem.byteenable = m1.byteenable;
                m1.waitrequest = mem.waitrequest;
                m1.readdata    = mem.readdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level owner/last reference model.
module tb_mips_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant;

    mips_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    mips_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    mips_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mips_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .mem   (mem_bus),
        .grant (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port (-1 = nobody) and who finished last.
    int owner = -1;
    int last  = 1;
    int done_cnt [2];

    typedef struct packed {
        logic [1:0]        grant;
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
        logic              wr0;
        logic              wr1;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
    } exp_t;

    function automatic void model_edge();
        bit r [2];
        r[0] = m0_bus.read | m0_bus.write;
        r[1] = m1_bus.read | m1_bus.write;
        if (reset) begin
            owner = -1;
            last  = 1;
        end else if (owner < 0) begin
            if (r[0] && r[1]) owner = 1 - last;
            else if (r[0])    owner = 0;
            else if (r[1])    owner = 1;
        end else if (!r[owner]) begin
            owner = -1;
        end else if (!mem_bus.waitrequest) begin
            done_cnt[owner]++;
            last  = owner;
            owner = r[1 - owner] ? 1 - owner : -1;
        end
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e     = '0;
        e.wr0 = 1'b1;
        e.wr1 = 1'b1;
        if (owner == 0) begin
            e.grant = 2'b01;
            e.read = m0_bus.read; e.write = m0_bus.write; e.address = m0_bus.address;
            e.writedata = m0_bus.writedata; e.byteenable = m0_bus.byteenable;
            e.wr0 = mem_bus.waitrequest; e.rd0 = mem_bus.readdata;
        end else if (owner == 1) begin
            e.grant = 2'b10;
            e.read = m1_bus.read; e.write = m1_bus.write; e.address = m1_bus.address;
            e.writedata = m1_bus.writedata; e.byteenable = m1_bus.byteenable;
            e.wr1 = mem_bus.waitrequest; e.rd1 = mem_bus.readdata;
        end
        return e;
    endfunction

    // One clock: the model takes the edge with the inputs in force, then inputs may change at negedge.
    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0;
        m0_bus.writedata = '0; m0_bus.byteenable = '0;
        m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0;
        m1_bus.writedata = '0; m1_bus.byteenable = '0;
        mem_bus.waitrequest = 1'b0; mem_bus.readdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        m0_bus.read = 1'b1; m1_bus.write = 1'b1; mem_bus.readdata = 32'h1234_5678;
        advance();
        advance();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++; if (mem_bus.read !== 1'b0 || mem_bus.write !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got read=%b write=%b expected 0 0", mem_bus.read, mem_bus.write); end
        checks++; if (mem_bus.address !== '0 || mem_bus.writedata !== '0 || mem_bus.byteenable !== '0) begin
            errors++; $display("FAIL reset_bus: got addr=%h wdata=%h be=%b expected zeros",
                               mem_bus.address, mem_bus.writedata, mem_bus.byteenable); end
        checks++; if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL reset_wait: got %b %b expected 1 1", m0_bus.waitrequest, m1_bus.waitrequest); end
        checks++; if (m0_bus.readdata !== '0 || m1_bus.readdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_bus.readdata, m1_bus.readdata); end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_master();
        m0_bus.address = 32'h0000_0010; m0_bus.read = 1'b1;
        mem_bus.waitrequest = 1'b0; mem_bus.readdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (grant !== 2'b00 || m0_bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL single_pre: got grant=%b wait=%b expected 00 1", grant, m0_bus.waitrequest); end
        advance();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
        checks++; if (mem_bus.read !== 1'b1 || mem_bus.address !== 32'h0000_0010) begin
            errors++; $display("FAIL single_fwd: got read=%b addr=%h expected 1 00000010", mem_bus.read, mem_bus.address); end
        checks++; if (m0_bus.waitrequest !== 1'b0 || m0_bus.readdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_done: got wait=%b rdata=%h expected 0 deadbeef",
                               m0_bus.waitrequest, m0_bus.readdata); end
        advance();
        m0_bus.read = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || mem_bus.read !== 1'b0) begin
            errors++; $display("FAIL single_idle: got grant=%b read=%b expected 00 0", grant, mem_bus.read); end
    endtask

    task automatic test_tie();
        do_reset();
        m0_bus.read = 1'b1; m0_bus.address = 32'h0000_0A00;
        m1_bus.read = 1'b1; m1_bus.address = 32'h0000_0B00;
        mem_bus.waitrequest = 1'b1;
        advance();
        checks++; if (grant !== 2'b01 || mem_bus.address !== 32'h0000_0A00) begin
            errors++; $display("FAIL tie_first: got grant=%b addr=%h expected 01 00000a00", grant, mem_bus.address); end
        advance();
        checks++; if (m1_bus.waitrequest !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL tie_hold: got m1_wait=%b grant=%b expected 1 01", m1_bus.waitrequest, grant); end
        mem_bus.waitrequest = 1'b0;
        #1;
        checks++; if (m1_bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL tie_m1_stall: got %b expected 1", m1_bus.waitrequest); end
        advance();
        checks++; if (grant !== 2'b10 || mem_bus.address !== 32'h0000_0B00 || mem_bus.read !== 1'b1) begin
            errors++; $display("FAIL tie_handoff: got grant=%b addr=%h read=%b expected 10 00000b00 1",
                               grant, mem_bus.address, mem_bus.read); end
        clear_inputs();
        advance();
    endtask

    task automatic test_round_robin();
        int cnt [2];
        cnt[0] = 0; cnt[1] = 0;
        do_reset();
        m0_bus.read = 1'b1; m1_bus.write = 1'b1; mem_bus.waitrequest = 1'b0;
        for (int i = 0; i < 8; i++) begin
            advance();
            checks++; if (grant !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant,
                                   (i % 2 == 0) ? 2'b01 : 2'b10); end
            if (grant[0] && !m0_bus.waitrequest) cnt[0]++;
            if (grant[1] && !m1_bus.waitrequest) cnt[1]++;
        end
        checks++; if (cnt[0] != 4 || cnt[1] != 4) begin
            errors++; $display("FAIL rr_count: got m0=%0d m1=%0d expected 4 4", cnt[0], cnt[1]); end
        clear_inputs();
        advance();
    endtask

    task automatic test_wait_states();
        do_reset();
        m1_bus.write = 1'b1; m1_bus.address = 32'h0000_1000;
        m1_bus.writedata = 32'hCAFE_F00D; m1_bus.byteenable = 4'b0011;
        mem_bus.waitrequest = 1'b1;
        advance();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_bus.waitrequest = 1'b0;
            #1;
            checks++; if (mem_bus.write !== 1'b1 || mem_bus.address !== 32'h0000_1000 ||
                          mem_bus.writedata !== 32'hCAFE_F00D || mem_bus.byteenable !== 4'b0011) begin
                errors++; $display("FAIL ws_bus[%0d]: got w=%b a=%h d=%h be=%b expected 1 00001000 cafef00d 0011",
                                   k, mem_bus.write, mem_bus.address, mem_bus.writedata, mem_bus.byteenable); end
            checks++; if (m1_bus.waitrequest !== (k < 3)) begin
                errors++; $display("FAIL ws_wait[%0d]: got %b expected %b", k, m1_bus.waitrequest, k < 3); end
            advance();
        end
        clear_inputs();
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ws_idle: got %b expected 00", grant); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_bus.read = 1'b1; m0_bus.address = 32'h0000_0020; mem_bus.waitrequest = 1'b0;
        advance();
        advance();
        mem_bus.waitrequest = 1'b1;
        advance();
        checks++; if (grant !== 2'b01 || m0_bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL rmid_own: got grant=%b wait=%b expected 01 1", grant, m0_bus.waitrequest); end
        reset = 1'b1;
        advance();
        checks++; if (mem_bus.read !== 1'b0 || mem_bus.write !== 1'b0 || grant !== 2'b00) begin
            errors++; $display("FAIL rmid_idle: got read=%b write=%b grant=%b expected 0 0 00",
                               mem_bus.read, mem_bus.write, grant); end
        checks++; if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL rmid_wait: got %b %b expected 1 1", m0_bus.waitrequest, m1_bus.waitrequest); end
        reset = 1'b0;
        m1_bus.read = 1'b1; mem_bus.waitrequest = 1'b0;
        advance();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_first: got %b expected 01", grant); end
        clear_inputs();
        advance();
    endtask

    task automatic test_drop();
        do_reset();
        m0_bus.read = 1'b1; mem_bus.waitrequest = 1'b1;
        advance();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL drop_own: got %b expected 01", grant); end
        m0_bus.read = 1'b0; m1_bus.read = 1'b1; m1_bus.address = 32'h0000_0300;
        advance();
        checks++; if (grant !== 2'b00 || m1_bus.waitrequest !== 1'b1 || mem_bus.read !== 1'b0) begin
            errors++; $display("FAIL drop_idle: got grant=%b m1_wait=%b read=%b expected 00 1 0",
                               grant, m1_bus.waitrequest, mem_bus.read); end
        advance();
        checks++; if (grant !== 2'b10 || mem_bus.read !== 1'b1 || mem_bus.address !== 32'h0000_0300) begin
            errors++; $display("FAIL drop_next: got grant=%b read=%b addr=%h expected 10 1 00000300",
                               grant, mem_bus.read, mem_bus.address); end
        clear_inputs();
        advance();
    endtask

    task automatic test_random();
        exp_t e;
        int   bad;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            m0_bus.read = 1'($urandom_range(0, 1)); m0_bus.write = ($urandom_range(0, 3) == 0);
            m0_bus.address = $urandom(); m0_bus.writedata = $urandom(); m0_bus.byteenable = 4'($urandom());
            m1_bus.read = 1'($urandom_range(0, 1)); m1_bus.write = ($urandom_range(0, 3) == 0);
            m1_bus.address = $urandom(); m1_bus.writedata = $urandom(); m1_bus.byteenable = 4'($urandom());
            mem_bus.waitrequest = ($urandom_range(0, 2) == 0); mem_bus.readdata = $urandom();
            #1;
            e   = model_expect();
            bad = 0;
            checks++; if (grant !== e.grant) begin
                errors++; bad++; $display("FAIL rnd_grant[%0d]: got %b expected %b", i, grant, e.grant); end
            checks++; if (mem_bus.read !== e.read || mem_bus.write !== e.write) begin
                errors++; bad++; $display("FAIL rnd_strobe[%0d]: got r=%b w=%b expected r=%b w=%b",
                                          i, mem_bus.read, mem_bus.write, e.read, e.write); end
            checks++; if (mem_bus.address !== e.address || mem_bus.writedata !== e.writedata ||
                          mem_bus.byteenable !== e.byteenable) begin
                errors++; bad++; $display("FAIL rnd_bus[%0d]: got %h %h %b expected %h %h %b", i, mem_bus.address,
                                          mem_bus.writedata, mem_bus.byteenable, e.address, e.writedata, e.byteenable); end
            checks++; if (m0_bus.waitrequest !== e.wr0 || m1_bus.waitrequest !== e.wr1) begin
                errors++; bad++; $display("FAIL rnd_wait[%0d]: got %b %b expected %b %b",
                                          i, m0_bus.waitrequest, m1_bus.waitrequest, e.wr0, e.wr1); end
            checks++; if (m0_bus.readdata !== e.rd0 || m1_bus.readdata !== e.rd1) begin
                errors++; bad++; $display("FAIL rnd_rdata[%0d]: got %h %h expected %h %h",
                                          i, m0_bus.readdata, m1_bus.readdata, e.rd0, e.rd1); end
            if (bad != 0 && errors > 50) break;
            advance();
        end
        reset = 1'b0;
        clear_inputs();
        advance();
    endtask

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        test_reset();
        test_single_master();
        test_tie();
        test_round_robin();
        test_wait_states();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares a single Avalon memory-mapped slave port between requesters, such as the CPU bus controller and a loader or DMA master. It sits between the masters and the memory/peripheral fabric. It grants whole transactions using round-robin priority, forwards the granted master's signals downstream, and stalls the other master with `waitrequest`. Read data follows the zero-latency Avalon convention used by the CPU: `readdata` is valid in the cycle `waitrequest` is low.

## Interface

Parameters
- `ADDR_W`, 32, address width for all ports.
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`.

Ports
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_address`, `m1_address`  in  ADDR_W  requester address.
- `m0_read`, `m1_read`  in  1  read request.
- `m0_write`, `m1_write`  in  1  write request.
- `m0_writedata`, `m1_writedata`  in  DATA_W  write data.
- `m0_byteenable`, `m1_byteenable`  in  DATA_W/8  byte lanes.
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to requester.
- `m0_readdata`, `m1_readdata`  out  DATA_W  read data to requester.
- `address`  out  ADDR_W  downstream address.
- `read`, `write`  out  1  downstream strobes.
- `writedata`  out  DATA_W  downstream write data.
- `byteenable`  out  DATA_W/8  downstream byte lanes.
- `waitrequest`  in  1  downstream stall.
- `readdata`  in  DATA_W  downstream read data.
- `grant`  out  2  one-hot owner, {m1,m0}; 2'b00 when idle.

## Operation

- A master requests when `mX_read | mX_write` is high.
- State machine states: IDLE, OWN0, OWN1. A register `last` holds the most recent owner; reset value is 1, so m0 wins the first tie.
- IDLE:
  - One requester active → go to OWNx at the next edge.
  - Both requesters active → grant the one that is not `last`.
  - No request → stay in IDLE.
- OWNx, forwarding:
  - The downstream port is driven combinationally from master x.
  - `mx_waitrequest = waitrequest`.
  - `mx_readdata = readdata`.
  - `grant[x] = 1`.
- OWNx, completion: when master x requests and `waitrequest = 0`, the transaction is done. `last` is set to x. The next state is:
  - OWN of the other master, if the other master is requesting in that cycle (no idle bubble);
  - otherwise IDLE.
  - Master x's next request always waits at least one cycle, so back-to-back masters alternate.
- OWNx, drop: if master x drops its request while owning (a protocol violation), go to IDLE at the next edge. `last` is unchanged.
- Non-owner master:
  - `waitrequest` is held at 1.
  - `readdata` is driven to 0.
- IDLE outputs:
  - Both `mX_waitrequest` are 1.
  - Downstream `read`, `write`, `address`, `writedata` and `byteenable` are all 0.
  - `grant` is 00.
- A master asserting both read and write is forwarded unmodified. The arbiter does not correct it.
- Requests are never reordered, merged or buffered. Each master sees exactly one completion per transaction.

## Timing

- Reset values, in IDLE with `last` = 1:
  - `read`, `write` = 0.
  - `address`, `writedata`, `byteenable` = 0.
  - `m0_waitrequest`, `m1_waitrequest` = 1.
  - `m0_readdata`, `m1_readdata` = 0.
  - `grant` = 00.
- Arbitration latency is 1 cycle. A request first seen in IDLE at edge N is granted after edge N. Downstream strobes are visible in cycle N+1.
- Transaction length in the owned state is the downstream wait count + 1 cycle. Single-cycle memory gives a 2-cycle access from IDLE.
- Handoff: a pending other master is granted at the completion edge. Its strobes appear in the very next cycle.
- Reset asserted mid-transaction: IDLE after the edge and all downstream strobes 0. The in-flight access is abandoned and no completion is signalled.
- All outputs are combinational from state plus inputs. There is no registered data path.

## Test plan

- **Single master.** Reset, then m0 reads 0x00000010 with downstream `waitrequest` low and `readdata` 0xDEADBEEF.
  - `grant` = 01 one cycle after the request.
  - `m0_waitrequest` drops in that cycle with `m0_readdata` = 0xDEADBEEF.
  - State returns to IDLE.
- **Tie after reset.** m0 and m1 request in the same cycle.
  - m0 is granted first.
  - On m0's completion, m1 is granted at the same edge with no IDLE cycle.
  - `m1_waitrequest` stays 1 throughout m0's transaction.
- **Round-robin under continuous load.** Both masters request continuously for 8 transactions with 0 wait states.
  - Grants alternate 01, 10, 01, 10, …
  - Each master gets exactly 4 completions.
- **Downstream wait states.** m1 writes 0xCAFEF00D to 0x00001000 with byteenable 4'b0011, and `waitrequest` is held high for 3 cycles.
  - Downstream `write`, `address`, `writedata` and `byteenable` are stable for 4 cycles.
  - `m1_waitrequest` falls only in the 4th cycle.
- **Reset mid-transaction.** Assert `reset` while OWN0 waits on `waitrequest` = 1.
  - Next cycle: `read` = `write` = 0, `grant` = 00, both `mX_waitrequest` = 1.
  - The first request after reset is won by m0.
- **Owner drops request.** m0 deasserts `read` while owning with `waitrequest` = 1.
  - IDLE next cycle.
  - A pending m1 is granted on the following edge.
